// File: rtl/ins_fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, the NOP word, and the
// opcode / immediate-type constants used by decode.
package ins_fetch_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_FULL  = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] INS_NOP = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   function automatic imm_type_e imm_type_of(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC:            return IMM_U;
         OPC_JAL:                       return IMM_J;
         OPC_JALR, OPC_LOAD, OPC_OPIMM: return IMM_I;
         OPC_BRANCH:                    return IMM_B;
         OPC_STORE:                     return IMM_S;
         default:                       return IMM_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// Instruction-memory read bus: request/address out, same-cycle ack/data back.
interface ins_fetch_if;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport master (output mem_req_o, output mem_addr_o,
                   input  mem_ack_i, input  mem_rdata_i);
   modport slave  (input  mem_req_o, input  mem_addr_o,
                   output mem_ack_i, output mem_rdata_i);
endinterface

// File: rtl/ins_fetch_ins_buf.sv
// One-entry instruction buffer holding {instruction, pc} plus an occupancy flag.
module ins_buf
   import ins_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_clear,
   input  logic [31:0] i_ins,
   input  logic [31:0] i_pc,
   output logic        o_valid,
   output logic [31:0] o_ins,
   output logic [31:0] o_pc
);

   logic        r_valid;
   logic [31:0] r_ins;
   logic [31:0] r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ins   <= INS_NOP;
         r_pc    <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_ins   <= i_ins;
         r_pc    <= i_pc;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_ins   = r_ins;
   assign o_pc    = r_pc;

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: pc register, FETCH/FULL/HALT control and one-entry buffer.
// Define FETCH_ALIGN_CHECK_EN to halt with a sticky fault on misaligned redirects.
module ins_fetch
   import ins_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_i,
   input  logic [31:0]        redirect_pc_i,
   ins_fetch_if.master        mem,
   output logic               ins_valid_o,
   output logic [31:0]        ins_o,
   output logic [31:0]        ins_pc_o,
   input  logic               ins_ready_i,
   output logic               fault_o
);

   fetch_state_e r_state;
   fetch_state_e w_state_next;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_next;
   logic         w_req;
   logic         w_ack;
   logic         w_load;
   logic         w_clear;
   logic         w_misalign;
   logic         w_fault_set;

`ifdef FETCH_ALIGN_CHECK_EN
   logic r_fault;
   assign w_misalign = |redirect_pc_i[1:0];
   assign fault_o    = r_fault;

   always_ff @(posedge clk) begin
      if (rst)              r_fault <= 1'b0;
      else if (w_fault_set) r_fault <= 1'b1;
   end
`else
   assign w_misalign = 1'b0;
   assign fault_o    = 1'b0;
`endif

   // FULL requests only when decode drains the buffer this cycle.
   assign w_req = !rst && ((r_state == ST_FETCH) ||
                           ((r_state == ST_FULL) && ins_ready_i));
   assign w_ack = w_req && mem.mem_ack_i;

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_load       = 1'b0;
      w_clear      = 1'b0;
      w_fault_set  = 1'b0;
      if (r_state == ST_HALT) begin
         w_state_next = ST_HALT;
      end else if (redirect_i) begin
         w_clear = 1'b1;
         if (w_misalign) begin
            w_state_next = ST_HALT;
            w_fault_set  = 1'b1;
         end else begin
            w_pc_next    = redirect_pc_i & 32'hFFFF_FFFC;
            w_state_next = ST_FETCH;
         end
      end else if (w_ack) begin
         w_load       = 1'b1;
         w_pc_next    = r_pc + 32'd4;
         w_state_next = ST_FULL;
      end else if ((r_state == ST_FULL) && ins_ready_i) begin
         w_clear      = 1'b1;
         w_state_next = ST_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
      end
   end

   ins_buf u_ins_buf (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_clear (w_clear),
      .i_ins   (mem.mem_rdata_i),
      .i_pc    (r_pc),
      .o_valid (ins_valid_o),
      .o_ins   (ins_o),
      .o_pc    (ins_pc_o)
   );

   assign mem.mem_req_o  = w_req;
   assign mem.mem_addr_o = r_pc;

endmodule
